switch_axil_regs: RTL and testbench

SWITCH_AXIL_REGS -- requirements
Module: switch_axil_regs

---
 rtl/switch_axil_regs.sv | 151 +++++++++++++++
 tb/tb_switch_axil_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers; the low byte(s) of
// register 0 drive the led_out port.
module switch_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_LED_WIDTH        = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_LED_WIDTH-1:0]          led_out
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  logic              r_rdy_en;
  logic              r_aw_held;
  logic [1:0]        r_aw_idx;
  logic              r_w_held;
  logic [DW-1:0]     r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_bvalid;
  logic              r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic [DW-1:0]     r_slv_reg [4];
  logic [C_LED_WIDTH-1:0] r_led;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic [DW-1:0] w_merged;
  logic          w_unused;

  // Readies stay low during reset and rise at the first edge after release.
  assign S_AXI_AWREADY = r_rdy_en && !r_aw_held && !r_bvalid;
  assign S_AXI_WREADY  = r_rdy_en && !r_w_held && !r_bvalid;
  assign S_AXI_ARREADY = r_rdy_en && !r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign led_out       = r_led;

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit = r_aw_held && r_w_held;

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_byte_merge
      assign w_merged[gi*8 +: 8] = r_wstrb[gi] ? r_wdata[gi*8 +: 8]
                                               : r_slv_reg[r_aw_idx][gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // Address and data are captured independently; commit fires once both are held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= 2'd0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
        if (r_bvalid && S_AXI_BREADY) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        r_slv_reg[i] <= '0;
      end
    end else if (w_commit) begin
      r_slv_reg[r_aw_idx] <= w_merged;
    end
  end

  // A read at the commit edge samples the register before the write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_slv_reg[S_AXI_ARADDR[3:2]];
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_led <= '0;
    end else begin
      r_led <= r_slv_reg[0][C_LED_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_switch_axil_regs.sv
// Randomized self-checking bench for switch_axil_regs against a register-array
// reference model.
module tb_switch_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  led_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_regs [4];

  always #5 clk = ~clk;

  switch_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_LED_WIDTH(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .led_out(led_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) model_regs[addr[3:2]][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'h0, awready}, 32'h0);
    chk({tag, "_wready"},  {31'h0, wready},  32'h0);
    chk({tag, "_arready"}, {31'h0, arready}, 32'h0);
    chk({tag, "_bvalid"},  {31'h0, bvalid},  32'h0);
    chk({tag, "_rvalid"},  {31'h0, rvalid},  32'h0);
    chk({tag, "_bresp"},   {30'h0, bresp},   32'h0);
    chk({tag, "_rresp"},   {30'h0, rresp},   32'h0);
    chk({tag, "_rdata"},   rdata,            32'h0);
    chk({tag, "_led"},     {24'h0, led_out}, 32'h0);
  endtask

  // Write with independent AW/W start delays and a BREADY hold-off.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs;
    bit w_hs;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      if (aw_done) chk("aw_held_awready", {31'h0, awready}, 32'h0);
      if (w_done)  chk("w_held_wready",   {31'h0, wready},  32'h0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      cyc++;
    end
    @(negedge clk);
    awvalid = 0;
    wvalid  = 0;
    if (!(aw_done && w_done)) begin
      chk("wr_handshake_timeout", 32'h0, 32'h1);
      return;
    end
    chk("b_not_early", {31'h0, bvalid}, 32'h0);
    @(negedge clk);
    chk("b_latency", {31'h0, bvalid}, 32'h1);
    chk("bresp",     {30'h0, bresp},  32'h0);
    model_write(addr, data, strb);
    for (int i = 0; i < b_dly; i++) begin
      chk("b_hold_bvalid",  {31'h0, bvalid},  32'h1);
      chk("b_hold_awready", {31'h0, awready}, 32'h0);
      chk("b_hold_wready",  {31'h0, wready},  32'h0);
      @(negedge clk);
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    chk("b_clear",     {31'h0, bvalid},  32'h0);
    chk("awready_ret", {31'h0, awready}, 32'h1);
    chk("led",         {24'h0, led_out}, {24'h0, model_regs[0][7:0]});
    $display("WR addr=0x%0h data=0x%08h strb=0x%0h awdly=%0d wdly=%0d bdly=%0d",
             addr, data, strb, aw_dly, w_dly, b_dly);
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
    int cyc = 0;
    bit hs = 0;
    logic [31:0] exp;
    data = 32'h0;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      arvalid = 1;
      araddr  = addr;
      hs = arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 0;
    if (!hs) begin
      chk("rd_handshake_timeout", 32'h0, 32'h1);
      return;
    end
    exp = model_regs[addr[3:2]];
    data = rdata;
    chk("rvalid", {31'h0, rvalid}, 32'h1);
    chk("rresp",  {30'h0, rresp},  32'h0);
    chk("rdata",  rdata,           exp);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("r_hold_rvalid",  {31'h0, rvalid},  32'h1);
      chk("r_hold_rdata",   rdata,            exp);
      chk("r_hold_arready", {31'h0, arready}, 32'h0);
    end
    rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
    chk("r_clear",     {31'h0, rvalid},  32'h0);
    chk("arready_ret", {31'h0, arready}, 32'h1);
    $display("RD addr=0x%0h data=0x%08h exp=0x%08h rdly=%0d", addr, data, exp, r_dly);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    rst_n = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1;
    #1;
    chk("rel_awready_low", {31'h0, awready}, 32'h0);
    @(negedge clk);
    chk("rel_awready", {31'h0, awready}, 32'h1);
    chk("rel_wready",  {31'h0, wready},  32'h1);
    chk("rel_arready", {31'h0, arready}, 32'h1);

    // Basic write/readback of all four registers.
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      do_write(a, 32'(i + 1), 4'hF, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      do_read(a, 0, rd);
      chk("r029_const", rd, 32'(i + 1));
    end
    chk("led_029", {24'h0, led_out}, 32'h1);

    // W three cycles ahead of AW.
    do_write(4'h8, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
    do_read(4'h8, 0, rd);
    chk("r030_const", rd, 32'hA5A5A5A5);

    // Byte strobes, including all-zero strobe.
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(4'h4, 32'h12345678, 4'h5, 1, 0, 0);
    do_read(4'h4, 0, rd);
    chk("r031_const", rd, 32'hFF34FF78);
    do_write(4'h4, 32'h00000000, 4'h0, 0, 2, 0);
    do_read(4'h4, 0, rd);
    chk("r031_zero_strb", rd, 32'hFF34FF78);

    // Back-pressure on both response channels.
    do_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 0, 10);
    do_read(4'hC, 10, rd);

    // Read handshake at the same edge as a commit to the same register.
    @(negedge clk);
    awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'h99; wstrb = 4'hF;
    chk("r033_awready", {31'h0, awready}, 32'h1);
    chk("r033_wready",  {31'h0, wready},  32'h1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 4'h0;
    chk("r033_arready", {31'h0, arready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    chk("r033_bvalid", {31'h0, bvalid}, 32'h1);
    chk("r033_rvalid", {31'h0, rvalid}, 32'h1);
    chk("r033_old",    rdata,           model_regs[0]);
    model_write(4'h0, 32'h99, 4'hF);
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    chk("r033_bclr", {31'h0, bvalid}, 32'h0);
    chk("r033_rclr", {31'h0, rvalid}, 32'h0);
    $display("OVERLAP read 0x0 old value during commit of 0x99");
    do_read(4'h0, 0, rd);
    chk("r033_new", rd, 32'h99);

    // Randomized mixed traffic.
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      do_write(a, d, s, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      do_read(a, $urandom_range(0, 3), rd);
    end

    // Reset with an address held and no data yet.
    @(negedge clk);
    awvalid = 1; awaddr = 4'hC;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0;
    chk("r034_aw_held", {31'h0, awready}, 32'h0);
    rst_n = 0;
    #1;
    model_reset();
    check_reset_outputs("r034");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("r034_awready", {31'h0, awready}, 32'h1);
    chk("r034_wready",  {31'h0, wready},  32'h1);
    $display("RESET mid-transaction applied and released");
    do_read(4'h0, 0, rd);
    do_write(4'hC, 32'h5EED1234, 4'hF, 0, 1, 0);
    do_read(4'hC, 0, rd);
    chk("r034_const", rd, 32'h5EED1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
